// File: rtl/regfile_pkg.sv
// Shared constants for the multi-read-port register file.
// Holds the default geometry and the clear-engine state encoding used by
// regfile_clr_fsm and regfile_mp.
package regfile_pkg;

    // Default geometry: matches the legacy 32x32 two-read-port file.
    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;
    localparam int unsigned RF_NREAD = 2;

    // Clear-engine state encoding.
    localparam logic CLR_ST_IDLE  = 1'b0;
    localparam logic CLR_ST_CLEAR = 1'b1;

endpackage : regfile_pkg

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine for regfile_mp.
// On a clear request it walks the pointer from entry 1 up to entry NREGS-1,
// issuing one clear-write per cycle, then returns to idle. Entry 0 is never
// visited because it is hardwired to zero in the file itself.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_req_i,
    output logic          clr_busy_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

    logic          state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    // Next state: start on request from idle, wrap back to idle after the last entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLR_ST_IDLE) begin
            // Requests while clearing are ignored by construction.
            if (clr_req_i) begin
                state_d = CLR_ST_CLEAR;
                ptr_d   = PTR_FIRST;
            end
        end else begin
            if (ptr_q == PTR_LAST) begin
                state_d = CLR_ST_IDLE;
                ptr_d   = PTR_FIRST;
            end else begin
                ptr_d = ptr_q + PTR_FIRST;
            end
        end
    end

    // State and pointer registers; reset aborts any clear in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLR_ST_IDLE;
            ptr_q   <= PTR_FIRST;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outputs decode from the registers only, so WRDY has no input path.
    always_comb begin
        clr_busy_o = (state_q == CLR_ST_CLEAR);
        clr_we_o   = (state_q == CLR_ST_CLEAR);
        clr_addr_o = ptr_q;
    end

endmodule : regfile_clr_fsm

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with pending-write scoreboard
// and sequential clear engine.
// Optional feature macro: RF_BYPASS_EN -- when defined, a same-cycle accepted
// write is forwarded to matching read ports (write-first); when undefined,
// reads return the stored value (read-old).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = RF_XLEN,
    parameter int unsigned NREGS = RF_NREGS,
    parameter int unsigned NREAD = RF_NREAD,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  WE,
    input  logic [AW-1:0]         WDA,
    input  logic [XLEN-1:0]       WD,
    output logic                  WRDY,
    input  logic [NREAD*AW-1:0]   RA,
    output logic [NREAD*XLEN-1:0] RD,
    output logic [NREAD-1:0]      RBUSY,
    input  logic                  ISS_V,
    input  logic [AW-1:0]         ISS_A,
    input  logic                  CLR_REQ,
    output logic                  CLR_BUSY
);

    logic [XLEN-1:0]  ram_q [NREGS];
    logic [XLEN-1:0]  ram_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_acc;
    logic          iss_acc;
    logic [AW-1:0] ra_addr [NREAD];

    regfile_clr_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_fsm (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .clr_req_i  (CLR_REQ),
        .clr_busy_o (CLR_BUSY),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Write port is stalled for the whole clear; the producer retries.
    always_comb begin
        WRDY    = !CLR_BUSY;
        wr_acc  = WE && !CLR_BUSY && (WDA != '0);
        iss_acc = ISS_V && !CLR_BUSY && (ISS_A != '0);
    end

    // RAM next state: accepted write or clear-write; entry 0 pinned to zero.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            ram_d[i] = ram_q[i];
        end
        if (wr_acc) begin
            ram_d[WDA] = WD;
        end
        // Never coincides with wr_acc because WRDY is low while clearing.
        if (clr_we) begin
            ram_d[clr_addr] = '0;
        end
        ram_d[0] = '0;
    end

    // Scoreboard next state: write clears, issue sets; the set is applied last so it wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_acc) begin
            pend_d[WDA] = 1'b0;
        end
        if (clr_we) begin
            pend_d[clr_addr] = 1'b0;
        end
        if (iss_acc) begin
            pend_d[ISS_A] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Storage and scoreboard registers, zeroed by reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREGS; i++) begin
                ram_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                ram_q[i] <= ram_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Unpack the read-address bus into per-port addresses.
    always_comb begin
        for (int k = 0; k < NREAD; k++) begin
            ra_addr[k] = RA[k*AW +: AW];
        end
    end

    // Read multiplexers and scoreboard lookup, with optional write forwarding.
    always_comb begin
        RD    = '0;
        RBUSY = '0;
        for (int k = 0; k < NREAD; k++) begin
            if (ra_addr[k] != '0) begin
                RD[k*XLEN +: XLEN] = ram_q[ra_addr[k]];
                RBUSY[k]           = pend_q[ra_addr[k]];
            end
`ifdef RF_BYPASS_EN
            if (wr_acc && (ra_addr[k] == WDA)) begin
                RD[k*XLEN +: XLEN] = WD;
                // A same-cycle issue to the same register keeps it pending.
                if (!(iss_acc && (ISS_A == WDA))) begin
                    RBUSY[k] = 1'b0;
                end
            end
`endif
        end
    end

    // Structural invariants.
    a_wrdy_vs_busy : assert property (@(posedge CLK) WRDY == !CLR_BUSY);
    a_r0_not_pend  : assert property (@(posedge CLK) disable iff (!RESET_N) pend_q[0] == 1'b0);

endmodule : regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the processor datapath, successor to the fixed 32×32, two-read-port file. It provides NREAD combinational read ports, one write port with entry 0 hardwired to zero, a pending-write scoreboard for hazard detection, and a sequential clear engine that zeroes the file one entry per cycle without asserting reset. It sits between the decode stage (read and issue) and the writeback stage (write).

## Interface
Parameters:
- XLEN, 32: data width in bits.
- NREGS, 32: number of entries; power of two, at least 2.
- NREAD, 2: number of read ports, 1 to 4.
- AW, $clog2(NREGS): address width (derived; do not override).

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- WE  in  1  write enable.
- WDA  in  AW  write address.
- WD  in  XLEN  write data.
- WRDY  out  1  write accepted this cycle; equals !CLR_BUSY.
- RA  in  NREAD*AW  read addresses; port k is bits [k*AW +: AW].
- RD  out  NREAD*XLEN  read data; port k is bits [k*XLEN +: XLEN].
- RBUSY  out  NREAD  scoreboard pending bit for each read address.
- ISS_V  in  1  issue valid; marks ISS_A as pending.
- ISS_A  in  AW  destination register being issued.
- CLR_REQ  in  1  single-cycle request to start a sequential clear.
- CLR_BUSY  out  1  clear engine active.

## Operation
- **Entry 0:**
  - Always reads as 0 and is never pending.
  - Writes and issues to address 0 are discarded.
- **Write:** when WE && WRDY && WDA != 0, RAM[WDA] <= WD at the clock edge. When WE && !WRDY, the write is dropped; the producer must hold it and retry.
- **Read:**
  - RD port k = RAM[RA_k], combinational.
  - If RA_k == 0, RD port k = 0.
- **Scoreboard:** one pending bit per entry.
  - An accepted write to address a clears pend[a].
  - ISS_V with ISS_A != 0 sets pend[ISS_A].
  - If an issue and an accepted write target the same address in one cycle, the set wins and pend stays 1.
  - RBUSY[k] = pend[RA_k].
  - ISS_V is ignored while CLR_BUSY is high.
- **Clear engine states:**
  - IDLE: on CLR_REQ, go to CLEAR with ptr = 1.
  - CLEAR: each cycle, RAM[ptr] <= 0 and pend[ptr] <= 0, then ptr increments. When ptr == NREGS-1, that entry is cleared and the engine returns to IDLE.
  - CLR_BUSY = (state == CLEAR).
  - CLR_REQ while in CLEAR is ignored.
- **Reset (RESET_N low):**
  - All RAM entries = 0, all pend = 0.
  - State = IDLE, ptr = 1.
  - Output values under reset: CLR_BUSY = 0, WRDY = 1, RBUSY = 0, RD = 0 on every port.
  - Assertion mid-clear aborts the clear immediately.

## Timing
- Write-to-read latency:
  - Without bypass (see Configuration), a write becomes visible on RD in the cycle after the edge that stores it.
  - Scoreboard updates are visible on RBUSY in the cycle after the edge.
- Clear duration:
  - CLR_REQ sampled at edge t.
  - CLR_BUSY is high from after edge t until after edge t+NREGS-1, i.e. for NREGS-1 cycles.
  - WRDY = 0 during the same cycles.
  - The cycle after CLR_BUSY falls, all entries read 0.
- Reads during a clear return the current RAM contents; entries not yet reached keep their old values.
- WRDY is combinational from the state register only; it has no path from WE.

## Configuration
- **RF_BYPASS_EN defined:** a same-cycle accepted write is forwarded to matching read ports.
  - Condition: WE && WRDY && WDA != 0 && RA_k == WDA.
  - Effect: RD port k = WD (write-first behaviour).
  - RBUSY[k] is forced to 0 under the same condition, unless ISS_V targets the same address in that cycle.
- **RF_BYPASS_EN undefined:** read-old behaviour, as described in Timing.

## Structure
- **Shared package regfile_pkg:**
  - Default constants RF_XLEN = 32, RF_NREGS = 32, RF_NREAD = 2.
  - Clear-engine state encoding: IDLE = 1'b0, CLEAR = 1'b1.
- **Sub-module regfile_clr_fsm:** the clear state machine and pointer. Outputs CLR_BUSY, the clear-write enable and the clear address.
- **Top level:** holds the RAM, the pending-bit vector, the read multiplexers and the bypass logic.

## Test plan
- **Reset:** reset, then read all addresses on every port → all RD = 0, RBUSY = 0, WRDY = 1, CLR_BUSY = 0.
- **Write and zero register:**
  - Write 0xDEADBEEF to r5, then read r5 next cycle → 0xDEADBEEF.
  - Write 0x1234 to r0 → r0 reads 0.
- **Scoreboard:**
  - Issue r7 → RBUSY for RA = 7 is 1 next cycle.
  - Write r7 → RBUSY is 0 the cycle after.
  - Issue and write r7 in the same cycle → RBUSY stays 1.
- **Clear:**
  - Fill r1..r31 with nonzero values, pulse CLR_REQ → CLR_BUSY high for exactly 31 cycles.
  - A write to r3 during the clear is dropped (WRDY = 0).
  - Afterwards, all entries read 0 and all pend bits are 0.
- **Reset mid-clear:** assert RESET_N = 0 at cycle 10 of a clear → CLR_BUSY falls immediately and all entries read 0.
- **Bypass (RF_BYPASS_EN):** write 0xA5 to r9 with RA0 = 9 in the same cycle → RD0 = 0xA5 that cycle. Without the macro, RD0 shows the old value.
